// File: rtl/ram_2p_bytewr.sv
// Dual-port (1W/1R) RAM with per-byte write enables, registered read with valid/error strobes,
// write-first forwarding on same-address collisions, and an optional post-reset zeroing sweep.
module ram_2p_bytewr #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_DEPTH  = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]   wr_be_i,
  input  logic                      rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      rd_valid_o,
  output logic                      rd_err_o,
  output logic                      ready_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  // One extra bit so DEPTH and the clear counter can represent 2^ADDRESS_WIDTH.
  localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] LAST  = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]    mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     wr_in_range;
  logic                     rd_in_range;
  logic                     wr_go;
  logic                     rd_go;

  // Requests are accepted only once ready_o was already high at the previous edge.
  assign wr_in_range = {1'b0, wr_addr_i} < DEPTH;
  assign rd_in_range = {1'b0, rd_addr_i} < DEPTH;
  assign wr_go       = ready_o & wr_en_i & wr_in_range;
  assign rd_go       = ready_o & rd_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      clr_cnt <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state   <= ST_READY;
            ready_o <= 1'b1;
          end
        end
        ST_READY: ready_o <= 1'b1;
        default:  state   <= ST_READY;
      endcase
    end
  end

  // Storage array carries no reset; the INIT sweep is the only way it gets cleared.
  always_ff @(posedge clk_i) begin
    if (state == ST_INIT) begin
      mem[clr_cnt[ADDRESS_WIDTH-1:0]] <= '0;
    end else if (wr_go) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Write-first: enabled bytes of a same-address write override the stored word.
  always_comb begin
    rd_word = mem[rd_addr_i];
    if (wr_go && (wr_addr_i == rd_addr_i)) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be_i[b]) rd_word[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_go;
      rd_err_o   <= rd_go & ~rd_in_range;
      if (rd_go) rd_data_o <= rd_in_range ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_ram_2p_bytewr.sv
// Directed bench for ram_2p_bytewr: init sweep, byte enables, collision forwarding,
// back-to-back reads, out-of-range handling on a 20-word instance, and reset mid-operation.
module tb_ram_2p_bytewr;

  logic        clk;
  logic        rst_n;
  logic        wr_en,   rd_en;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_be;
  logic        rd_valid, rd_err, ready;

  logic        wr_en_s,   rd_en_s;
  logic [4:0]  wr_addr_s, rd_addr_s;
  logic [31:0] wr_data_s, rd_data_s;
  logic [3:0]  wr_be_s;
  logic        rd_valid_s, rd_err_s, ready_s;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  ram_2p_bytewr dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_err_o(rd_err), .ready_o(ready)
  );

  ram_2p_bytewr #(.MEMORY_DEPTH(20)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en_s), .wr_addr_i(wr_addr_s), .wr_data_i(wr_data_s), .wr_be_i(wr_be_s),
    .rd_en_i(rd_en_s), .rd_addr_i(rd_addr_s),
    .rd_data_o(rd_data_s), .rd_valid_o(rd_valid_s), .rd_err_o(rd_err_s), .ready_o(ready_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic drive_rd(input logic [4:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  task automatic small_rd(input logic [4:0] a, input logic [31:0] exp_d, input logic exp_e,
                          input string tag);
    rd_en_s = 1'b1; rd_addr_s = a;
    step();
    check({tag, "_valid"}, {31'd0, rd_valid_s}, 32'd1);
    check({tag, "_data"},  rd_data_s, exp_d);
    check({tag, "_err"},   {31'd0, rd_err_s}, {31'd0, exp_e});
    rd_en_s = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0; rd_en = 0; rd_addr = 0;
    wr_en_s = 0; wr_addr_s = 0; wr_data_s = 0; wr_be_s = 0; rd_en_s = 0; rd_addr_s = 0;

    // Reset values and init sequence with a read held at address 3
    drive_rd(5'd3);
    #12;
    check("rst_ready", {31'd0, ready},    32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_err",   {31'd0, rd_err},   32'd0);
    check("rst_data",  rd_data,           32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      check("init_ready",   {31'd0, ready},    (e == 32) ? 32'd1 : 32'd0);
      check("init_valid",   {31'd0, rd_valid}, 32'd0);
      check("init_ready_s", {31'd0, ready_s},  (e >= 20) ? 32'd1 : 32'd0);
    end
    step();
    check("first_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("first_rd_data",  rd_data,           32'h0000_0000);
    check("first_rd_err",   {31'd0, rd_err},   32'd0);
    rd_en = 1'b0;

    // Byte enables
    drive_wr(5'd7, 32'hAABB_CCDD, 4'hF);
    step();
    drive_wr(5'd7, 32'h1122_3344, 4'b0101);
    step();
    wr_en = 1'b0;
    drive_rd(5'd7);
    step();
    check("be_data", rd_data, 32'hAA22_CC44);
    rd_en = 1'b0;
    step();
    check("idle_valid", {31'd0, rd_valid}, 32'd0);
    check("idle_hold",  rd_data,           32'hAA22_CC44);

    // Collision, write-first
    drive_wr(5'd9, 32'hFFFF_FFFF, 4'hF);
    step();
    drive_wr(5'd9, 32'h1234_5678, 4'b0011);
    drive_rd(5'd9);
    step();
    wr_en = 1'b0;
    check("coll_valid", {31'd0, rd_valid}, 32'd1);
    check("coll_data",  rd_data,           32'hFFFF_5678);
    step();
    check("coll_reread", rd_data, 32'hFFFF_5678);
    rd_en = 1'b0;

    // Back-to-back reads after filling word i with i*0x01010101
    for (int i = 0; i < 32; i++) begin
      drive_wr(5'(i), i * 32'h0101_0101, 4'hF);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive_rd(5'(i));
      exp_q.push_back(i * 32'h0101_0101);
      step();
      check("b2b_valid", {31'd0, rd_valid}, 32'd1);
      check("b2b_data",  rd_data,           exp_q.pop_front());
    end
    rd_en = 1'b0;
    step();
    check("b2b_end_valid", {31'd0, rd_valid}, 32'd0);

    // Out of range on the 20-word instance
    wr_en_s = 1'b1; wr_be_s = 4'hF;
    wr_addr_s = 5'd9;  wr_data_s = 32'h0A0B_0C0D; step();
    wr_addr_s = 5'd19; wr_data_s = 32'h1313_1313; step();
    wr_addr_s = 5'd25; wr_data_s = 32'hDEAD_BEEF; step();
    wr_en_s = 1'b0;
    small_rd(5'd25, 32'h0000_0000, 1'b1, "oor_rd25");
    small_rd(5'd9,  32'h0A0B_0C0D, 1'b0, "oor_rd9");
    small_rd(5'd19, 32'h1313_1313, 1'b0, "oor_rd19");
    small_rd(5'd0,  32'h0000_0000, 1'b0, "oor_rd0");
    step();
    check("oor_idle_err", {31'd0, rd_err_s}, 32'd0);

    // Reset while a read result is showing
    drive_rd(5'd31);
    step();
    check("pre_rst_data", rd_data, 32'h1F1F_1F1F);
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready},    32'd0);
    check("midrst_valid", {31'd0, rd_valid}, 32'd0);
    check("midrst_data",  rd_data,           32'd0);
    #4 rst_n = 1'b1;

    // Reset again at init count 10; init must take a full 32 edges afterwards
    for (int e = 0; e < 10; e++) step();
    check("init10_ready", {31'd0, ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst10_ready", {31'd0, ready}, 32'd0);
    check("rst10_data",  rd_data,        32'd0);
    #3 rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      check("reinit_ready", {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
    end
    drive_rd(5'd7);
    step();
    check("reinit_clear_valid", {31'd0, rd_valid}, 32'd1);
    check("reinit_clear_data",  rd_data,           32'd0);
    rd_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_2p_bytewr.md
# ram_2p_bytewr

Parametrised successor to the single-port 5x32 RAM: one write port and one read port usable in the same cycle, per-byte write enables, a registered read with a valid strobe, and write-first forwarding on address collision. An optional post-reset sequencer zeroes the array before the block signals ready. It sits beside the core as general-purpose scratch or register-file storage.

## Interface

- ADDRESS_WIDTH, 5, address bits for both ports.
- DATA_WIDTH, 32, word width. Must be a multiple of 8.
- MEMORY_DEPTH, 32, number of words. Must be ≤ 2^ADDRESS_WIDTH.
- INIT_ON_RESET, 1, if 1, zero every word after reset before asserting ready_o.

Ports:

- clk_i  in  1  single clock; everything is sampled on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write request.
- wr_addr_i  in  ADDRESS_WIDTH  write address.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_be_i  in  DATA_WIDTH/8  byte enables; bit b covers data bits [8b+7:8b].
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDRESS_WIDTH  read address.
- rd_data_o  out  DATA_WIDTH  registered read data.
- rd_valid_o  out  1  one-cycle strobe marking rd_data_o as new.
- rd_err_o  out  1  qualifies rd_valid_o; high for an out-of-range read.
- ready_o  out  1  high once the block accepts requests.

## Operation

- **Reset (rst_ni low):**
  - ready_o=0, rd_valid_o=0, rd_err_o=0, rd_data_o=0.
  - The FSM goes to INIT if INIT_ON_RESET=1, otherwise to READY.
  - The array itself has no reset.
- **INIT state:**
  - A clear counter starts at 0.
  - Each edge writes all-zeros to memory[counter] and increments the counter.
  - The edge that writes word MEMORY_DEPTH-1 moves the FSM to READY.
  - wr_en_i and rd_en_i are ignored while in INIT; rd_valid_o stays 0.
- **READY state:** ready_o=1; the FSM stays here until the next reset.
- **Write (wr_en_i=1 in READY):**
  - For each b with wr_be_i[b]=1, byte b of memory[wr_addr_i] takes byte b of wr_data_i.
  - Bytes with wr_be_i[b]=0 are unchanged.
  - wr_be_i=0 is a legal no-op.
- **Read (rd_en_i=1 in READY):**
  - The next edge loads rd_data_o with memory[rd_addr_i] and sets rd_valid_o=1.
  - With rd_en_i=0, rd_valid_o=0 and rd_data_o holds its last value.
- **Collision (read and write in the same cycle, same address, both in range):** write-first. Each byte of the read result is wr_data_i where wr_be_i is set, and the old memory byte otherwise.
- **Out of range (address ≥ MEMORY_DEPTH):**
  - A write is dropped; no word is modified.
  - A read returns rd_data_o=0 with rd_valid_o=1 and rd_err_o=1 for that cycle.
  - rd_err_o=0 on every in-range read.
- **Reset mid-operation:**
  - All outputs return to their reset values immediately.
  - Any in-flight read result is lost.
  - INIT restarts from address 0.

## Timing

- Read latency is 1 cycle: request at edge N, rd_data_o and rd_valid_o valid after edge N+1.
- Reads and writes can be issued every cycle; no back-pressure exists once ready_o=1.
- Written data is visible:
  - to a read issued in the same cycle, through forwarding;
  - to any later read.
- With INIT_ON_RESET=1:
  - ready_o rises after the MEMORY_DEPTH-th rising edge following rst_ni deassertion (32 edges at defaults).
  - A request is accepted only in a cycle where ready_o was already 1 at the preceding edge.
- With INIT_ON_RESET=0, ready_o rises after the first edge following reset release.
- The clear counter is ADDRESS_WIDTH+1 bits wide so that MEMORY_DEPTH=2^ADDRESS_WIDTH terminates correctly.

## Test plan

- **Init sequence:** release reset and hold rd_en_i=1 at address 3 throughout.
  - ready_o must be 0 for exactly 32 edges, then 1.
  - No rd_valid_o during INIT.
  - The first read after ready_o returns 0x00000000.
- **Byte enables:** write 0xAABBCCDD to address 7 with be=4'hF, then write 0x11223344 to address 7 with be=4'b0101. A later read of address 7 returns 0xAA22CC44.
- **Collision:** memory[9]=0xFFFFFFFF; in the same cycle write 0x12345678 with be=4'b0011 and read address 9.
  - rd_data_o must be 0xFFFF5678 one cycle later.
  - A subsequent read returns the same value.
- **Back-to-back:** read addresses 0..31 on consecutive cycles after writing word i = i*0x01010101.
  - rd_valid_o is high for 32 consecutive cycles.
  - The data matches each address, offset by one cycle.
- **Out of range (MEMORY_DEPTH=20):**
  - Write 0xDEADBEEF to address 25: no word changes.
  - Read address 25: rd_data_o=0, rd_valid_o=1, rd_err_o=1.
- **Reset mid-init:** assert rst_ni at init count 10.
  - Outputs zero immediately.
  - After release, ready_o takes a full 32 cycles again.
